aclk_controller: RTL and testbench

ACLK_CONTROLLER -- requirements
Module: aclk_controller

---
 rtl/aclk_pkg.sv | 22 ++
 rtl/aclk_timeout.sv | 41 ++++
 rtl/aclk_controller.sv | 102 ++++++++++
 tb/tb_aclk_controller.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/aclk_pkg.sv
// Shared types and constants for the alarm-clock keypad controller.
package aclk_pkg;

    localparam int KEY_W = 4;
    localparam logic [KEY_W-1:0] NOKEY = 4'd10;

    typedef enum logic [2:0] {
        SHOW_TIME        = 3'd0,
        KEY_STORED       = 3'd1,
        KEY_WAITED       = 3'd2,
        KEY_ENTRY        = 3'd3,
        SHOW_ALARM       = 3'd4,
        SET_ALARM_TIME   = 3'd5,
        SET_CURRENT_TIME = 3'd6
    } aclk_state_t;

    // Codes 0-9 are digits; 10 and the unused codes 11-15 all mean "no key".
    function automatic logic is_digit(input logic [KEY_W-1:0] k);
        return (k < NOKEY);
    endfunction

endpackage

// File: rtl/aclk_timeout.sv
// Idle-seconds counter for key entry: counts one_second ticks while enabled,
// saturates at TIMEOUT_SEC and flags the tick that completes the idle period.
module aclk_timeout #(
    parameter int TIMEOUT_SEC = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_SEC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_SEC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_SEC);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise step on each tick until saturated.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register, forced to zero while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign timeout = !clear && tick && (count_q == CNT_LAST);

endmodule

// File: rtl/aclk_controller.sv
// Keypad/button sequencer for the alarm clock: Moore FSM that strobes key
// shifts and alarm/time loads and selects what the display shows.
module aclk_controller
    import aclk_pkg::*;
#(
    parameter int TIMEOUT_SEC = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             one_second,
    input  logic [KEY_W-1:0] key,
    input  logic             alarm_button,
    input  logic             time_button,
    output logic             shift,
    output logic             show_new_time,
    output logic             show_a,
    output logic             load_new_a,
    output logic             load_new_c
);

    aclk_state_t state_q;
    aclk_state_t state_d;
    logic        idleClear;
    logic        timeout;
    logic        keyDigit;

    assign keyDigit  = is_digit(key);
    assign idleClear = !((state_q == KEY_WAITED) || (state_q == KEY_ENTRY));

    aclk_timeout #(
        .TIMEOUT_SEC(TIMEOUT_SEC)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (idleClear),
        .tick   (one_second),
        .timeout(timeout)
    );

    // State register; reset abandons any entry in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SHOW_TIME;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a fresh digit outranks a coinciding timeout in KEY_ENTRY.
    always_comb begin
        state_d = SHOW_TIME;
        case (state_q)
            SHOW_TIME: begin
                if (alarm_button)  state_d = SHOW_ALARM;
                else if (keyDigit) state_d = KEY_STORED;
                else               state_d = SHOW_TIME;
            end
            KEY_STORED: state_d = KEY_WAITED;
            KEY_WAITED: begin
                if (!keyDigit)    state_d = KEY_ENTRY;
                else if (timeout) state_d = SHOW_TIME;
                else              state_d = KEY_WAITED;
            end
            KEY_ENTRY: begin
                if (alarm_button)     state_d = SET_ALARM_TIME;
                else if (time_button) state_d = SET_CURRENT_TIME;
                else if (keyDigit)    state_d = KEY_STORED;
                else if (timeout)     state_d = SHOW_TIME;
                else                  state_d = KEY_ENTRY;
            end
            SHOW_ALARM: begin
                if (alarm_button) state_d = SHOW_ALARM;
                else              state_d = SHOW_TIME;
            end
            SET_ALARM_TIME:   state_d = SHOW_TIME;
            SET_CURRENT_TIME: state_d = SHOW_TIME;
            default:          state_d = SHOW_TIME;
        endcase
    end

    // Moore output decode from the current state only.
    always_comb begin
        shift         = 1'b0;
        show_new_time = 1'b0;
        show_a        = 1'b0;
        load_new_a    = 1'b0;
        load_new_c    = 1'b0;
        case (state_q)
            KEY_STORED: begin
                shift         = 1'b1;
                show_new_time = 1'b1;
            end
            KEY_WAITED:       show_new_time = 1'b1;
            KEY_ENTRY:        show_new_time = 1'b1;
            SHOW_ALARM:       show_a        = 1'b1;
            SET_ALARM_TIME:   load_new_a    = 1'b1;
            SET_CURRENT_TIME: load_new_c    = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_aclk_controller.sv
// Self-checking bench for aclk_controller: each stimulus cycle pushes the
// hand-derived output vector {shift, show_new_time, show_a, load_new_a,
// load_new_c} onto a scoreboard, which is popped and compared after the edge.
module tb_aclk_controller;

    localparam logic [3:0] NK = 4'd10;

    localparam logic [4:0] O_IDLE  = 5'b00000;
    localparam logic [4:0] O_SHIFT = 5'b11000;
    localparam logic [4:0] O_SHOW  = 5'b01000;
    localparam logic [4:0] O_ALARM = 5'b00100;
    localparam logic [4:0] O_LDA   = 5'b00010;
    localparam logic [4:0] O_LDC   = 5'b00001;

    typedef struct {
        string      tag;
        logic [4:0] expected;
    } sbEntry_t;

    logic       clk;
    logic       reset;
    logic       oneSecond;
    logic [3:0] key;
    logic       alarmButton;
    logic       timeButton;
    logic       shift;
    logic       showNewTime;
    logic       showA;
    logic       loadNewA;
    logic       loadNewC;

    sbEntry_t   scoreboard[$];
    int         totalChecks;
    int         badChecks;

    aclk_controller #(
        .TIMEOUT_SEC(10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .one_second   (oneSecond),
        .key          (key),
        .alarm_button (alarmButton),
        .time_button  (timeButton),
        .shift        (shift),
        .show_new_time(showNewTime),
        .show_a       (showA),
        .load_new_a   (loadNewA),
        .load_new_c   (loadNewC)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [4:0] outVec();
        return {shift, showNewTime, showA, loadNewA, loadNewC};
    endfunction

    task automatic checkOutput(input string tag, input logic [4:0] observed, input logic [4:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %b expected %b", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
    task automatic applyStimulus(input logic [3:0] k, input logic ab, input logic tb, input logic sec,
                                 input logic [4:0] expected, input string tag);
        sbEntry_t entry;
        @(negedge clk);
        key         = k;
        alarmButton = ab;
        timeButton  = tb;
        oneSecond   = sec;
        entry.tag      = tag;
        entry.expected = expected;
        scoreboard.push_back(entry);
        @(posedge clk);
        #1;
        entry = scoreboard.pop_front();
        checkOutput(entry.tag, outVec(), entry.expected);
    endtask

    // One digit press and release starting from SHOW_TIME or KEY_ENTRY, ending in KEY_ENTRY.
    task automatic pressKey(input logic [3:0] d, input string tag);
        applyStimulus(d,  1'b0, 1'b0, 1'b0, O_SHIFT, {tag, "_store"});
        applyStimulus(NK, 1'b0, 1'b0, 1'b0, O_SHOW,  {tag, "_wait"});
        applyStimulus(NK, 1'b0, 1'b0, 1'b0, O_SHOW,  {tag, "_entry"});
    endtask

    // Idle seconds in KEY_ENTRY that must not yet time out.
    task automatic idleSeconds(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            applyStimulus(NK, 1'b0, 1'b0, 1'b1, O_SHOW, $sformatf("%s_sec%0d", tag, i + 1));
            applyStimulus(NK, 1'b0, 1'b0, 1'b0, O_SHOW, $sformatf("%s_gap%0d", tag, i + 1));
        end
    endtask

    initial begin
        totalChecks = 0;
        badChecks   = 0;
        reset       = 1'b0;
        oneSecond   = 1'b0;
        key         = NK;
        alarmButton = 1'b0;
        timeButton  = 1'b0;

        #1;
        checkOutput("resetState", outVec(), O_IDLE);
        @(negedge clk);
        reset = 1'b1;

        // Held key gives one shift, second key another.
        applyStimulus(4'd1, 1'b0, 1'b0, 1'b0, O_SHIFT, "hold_k1_c1");
        applyStimulus(4'd1, 1'b0, 1'b0, 1'b0, O_SHOW,  "hold_k1_c2");
        applyStimulus(4'd1, 1'b0, 1'b0, 1'b0, O_SHOW,  "hold_k1_c3");
        applyStimulus(NK,   1'b0, 1'b0, 1'b0, O_SHOW,  "hold_release");
        applyStimulus(4'd2, 1'b0, 1'b0, 1'b0, O_SHIFT, "hold_k2");
        applyStimulus(NK,   1'b0, 1'b0, 1'b0, O_SHOW,  "hold_k2_wait");
        applyStimulus(NK,   1'b0, 1'b0, 1'b0, O_SHOW,  "hold_k2_entry");
        applyStimulus(NK,   1'b0, 1'b1, 1'b0, O_LDC,   "hold_exit_ldc");
        applyStimulus(NK,   1'b0, 1'b0, 1'b0, O_IDLE,  "hold_exit_idle");

        // Four digits then time_button loads the clock.
        pressKey(4'd1, "t_d1");
        pressKey(4'd2, "t_d2");
        pressKey(4'd5, "t_d5");
        pressKey(4'd9, "t_d9");
        applyStimulus(NK, 1'b0, 1'b1, 1'b0, O_LDC,  "time_load");
        applyStimulus(NK, 1'b0, 1'b0, 1'b0, O_IDLE, "time_back");
        applyStimulus(NK, 1'b0, 1'b0, 1'b0, O_IDLE, "time_idle");

        // Alarm beats time when both buttons are held.
        pressKey(4'd0, "a_d0");
        pressKey(4'd7, "a_d7");
        applyStimulus(NK, 1'b1, 1'b1, 1'b0, O_LDA,  "alarm_prio");
        applyStimulus(NK, 1'b0, 1'b0, 1'b0, O_IDLE, "alarm_back");

        // Nine idle seconds keep entry, the tenth times out.
        pressKey(4'd3, "to_d3");
        idleSeconds(9, "to9");
        applyStimulus(NK, 1'b0, 1'b0, 1'b1, O_IDLE, "to_sec10");
        applyStimulus(NK, 1'b0, 1'b0, 1'b0, O_IDLE, "to_after");

        // A digit coinciding with the timeout second wins and restarts the count.
        pressKey(4'd4, "race_d4");
        idleSeconds(9, "race9");
        applyStimulus(4'd5, 1'b0, 1'b0, 1'b1, O_SHIFT, "race_keywins");
        applyStimulus(NK,   1'b0, 1'b0, 1'b0, O_SHOW,  "race_wait");
        applyStimulus(NK,   1'b0, 1'b0, 1'b0, O_SHOW,  "race_entry");
        idleSeconds(9, "race_again");
        applyStimulus(NK, 1'b0, 1'b0, 1'b1, O_IDLE, "race_timeout");

        // Unused key code 12 is treated as no key.
        applyStimulus(4'd12, 1'b0, 1'b0, 1'b0, O_IDLE, "key12_ignored");

        // Alarm display held with a key down; no shift during or after.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(4'd4, 1'b1, 1'b0, 1'b0, O_ALARM, $sformatf("show_a_%0d", i));
        end
        applyStimulus(NK, 1'b0, 1'b0, 1'b0, O_IDLE, "show_a_drop");

        // Reset in KEY_WAITED abandons the entry at once.
        applyStimulus(4'd6, 1'b0, 1'b0, 1'b0, O_SHIFT, "rst_store");
        applyStimulus(4'd6, 1'b0, 1'b0, 1'b0, O_SHOW,  "rst_waited");
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rst_async", outVec(), O_IDLE);
        @(posedge clk);
        #1;
        checkOutput("rst_held", outVec(), O_IDLE);
        @(negedge clk);
        key   = NK;
        reset = 1'b1;
        applyStimulus(NK,   1'b0, 1'b0, 1'b0, O_IDLE,  "rst_after");
        applyStimulus(4'd6, 1'b0, 1'b0, 1'b0, O_SHIFT, "rst_k6");
        applyStimulus(NK,   1'b0, 1'b0, 1'b0, O_SHOW,  "rst_k6_wait");
        applyStimulus(NK,   1'b0, 1'b0, 1'b0, O_SHOW,  "rst_k6_entry");
        applyStimulus(NK,   1'b1, 1'b0, 1'b0, O_LDA,   "rst_k6_lda");
        applyStimulus(NK,   1'b0, 1'b0, 1'b0, O_IDLE,  "rst_k6_done");

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
